mem_arbiter: RTL

Request arbiter directly upstream of the RAM2 controller. It accepts instruction-fetch requests from IF and load/store requests from EXE, and serialises them onto the controller's `need_to_work_*` / `mem_act` token interface. It returns each result to its requester with a one-cycle acknowledge. It also keeps a one-entry fetch buffer, so a repeated fetch of the same address needs no RAM access.

---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IF fetches and EXE loads/stores onto the
// RAM2 controller token interface, with a one-entry fetch buffer.
//
// Ports
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_ack/if_data         : fetch requester
//   exe_req/rd/wr/addr/wdata -> exe_ack/data  : load/store requester
//   need_to_work_*, mem_rd/wr, mem_addr_*,
//   mem_value_exe, mem_act                    : to controller
//   mem_act_back, *_work_done, *_result       : from controller
//   stall_if/stall_exe                        : combinational stalls
//   err                                       : sticky timeout flag
module mem_arbiter #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_data,
  input  logic              exe_req,
  input  logic              exe_rd,
  input  logic              exe_wr,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_wdata,
  output logic              exe_ack,
  output logic [DATA_W-1:0] exe_data,
  output logic              need_to_work_if,
  output logic              need_to_work_exe,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr_if,
  output logic [ADDR_W-1:0] mem_addr_exe,
  output logic [DATA_W-1:0] mem_value_exe,
  output logic [31:0]       mem_act,
  input  logic [31:0]       mem_act_back,
  input  logic              if_work_done,
  input  logic              exe_work_done,
  input  logic [DATA_W-1:0] if_result,
  input  logic [DATA_W-1:0] exe_result,
  output logic              stall_if,
  output logic              stall_exe,
  output logic              err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    EXE_WAIT,
    IF_WAIT
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_if_ack;
  logic [DATA_W-1:0]   r_if_data;
  logic                r_exe_ack;
  logic [DATA_W-1:0]   r_exe_data;
  logic                r_ntw_if;
  logic                r_ntw_exe;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_addr_if;
  logic [ADDR_W-1:0]   r_addr_exe;
  logic [DATA_W-1:0]   r_value_exe;
  logic [31:0]         r_mem_act;
  logic                r_err;
  logic                r_fc_valid;
  logic [ADDR_W-1:0]   r_fc_addr;
  logic [DATA_W-1:0]   r_fc_data;

  logic w_exe_go;
  logic w_if_go;
  logic w_exe_store;
  logic w_fc_hit;
  logic w_fc_inv;
  logic w_tok_ok;
  logic w_tmo;

  // ack gating stops a held request relaunching in its own ack cycle
  assign w_exe_go    = exe_req & ~r_exe_ack;
  assign w_if_go     = if_req & ~r_if_ack;
  // rd wins when both strobes are set
  assign w_exe_store = exe_wr & ~exe_rd;
  assign w_fc_hit    = r_fc_valid & (r_fc_addr == if_addr);
  assign w_fc_inv    = r_fc_valid & (r_fc_addr == exe_addr);
  // a done flag only counts if it belongs to our current token
  assign w_tok_ok    = (mem_act_back == r_mem_act);
  assign w_tmo       = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_if_ack    <= 1'b0;
      r_if_data   <= '0;
      r_exe_ack   <= 1'b0;
      r_exe_data  <= '0;
      r_ntw_if    <= 1'b0;
      r_ntw_exe   <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_addr_if   <= '0;
      r_addr_exe  <= '0;
      r_value_exe <= '0;
      r_mem_act   <= '0;
      r_err       <= 1'b0;
      r_fc_valid  <= 1'b0;
      r_fc_addr   <= '0;
      r_fc_data   <= '0;
    end else begin
      r_if_ack  <= 1'b0;
      r_exe_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_exe_go) begin
            r_addr_exe  <= exe_addr;
            r_value_exe <= exe_wdata;
            r_mem_rd    <= exe_rd;
            r_mem_wr    <= w_exe_store;
            r_mem_act   <= r_mem_act + 32'd1;
            r_ntw_exe   <= 1'b1;
            r_cnt       <= '0;
            r_state     <= EXE_WAIT;
            if (w_exe_store && w_fc_inv)
              r_fc_valid <= 1'b0;
          end else if (w_if_go) begin
            if (w_fc_hit) begin
              r_if_ack  <= 1'b1;
              r_if_data <= r_fc_data;
            end else begin
              r_addr_if <= if_addr;
              r_mem_act <= r_mem_act + 32'd1;
              r_ntw_if  <= 1'b1;
              r_cnt     <= '0;
              r_state   <= IF_WAIT;
            end
          end
        end
        EXE_WAIT: begin
          if (exe_work_done && w_tok_ok) begin
            r_exe_data <= exe_result;
            r_exe_ack  <= 1'b1;
            r_ntw_exe  <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_state    <= IDLE;
          end else if (w_tmo) begin
            r_err     <= 1'b1;
            r_ntw_exe <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        IF_WAIT: begin
          if (if_work_done && w_tok_ok) begin
            r_if_data  <= if_result;
            r_if_ack   <= 1'b1;
            r_fc_addr  <= r_addr_if;
            r_fc_data  <= if_result;
            r_fc_valid <= 1'b1;
            r_ntw_if   <= 1'b0;
            r_state    <= IDLE;
          end else if (w_tmo) begin
            r_err    <= 1'b1;
            r_ntw_if <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_ack           = r_if_ack;
  assign if_data          = r_if_data;
  assign exe_ack          = r_exe_ack;
  assign exe_data         = r_exe_data;
  assign need_to_work_if  = r_ntw_if;
  assign need_to_work_exe = r_ntw_exe;
  assign mem_rd           = r_mem_rd;
  assign mem_wr           = r_mem_wr;
  assign mem_addr_if      = r_addr_if;
  assign mem_addr_exe     = r_addr_exe;
  assign mem_value_exe    = r_value_exe;
  assign mem_act          = r_mem_act;
  assign err              = r_err;
  assign stall_if         = if_req & ~r_if_ack;
  assign stall_exe        = exe_req & ~r_exe_ack;

endmodule
